// File: rtl/zld_dec.sv
// zld_dec - zero run-length decoder.
//
// Expands a stream of literal words and zero-run tokens back into the
// original word stream. A word with bit W-1 set is a run token carrying a
// count c in bits CNTW-1:0 and expands to c+1 zero words. Any other word is a
// literal and passes through unchanged. Both sides use a valid/back-pressure
// handshake, and a transfer happens on a rising edge with valid=1 and
// back-pressure=0.
//
// Ports:
//   clock   in   1     clock
//   reset   in   1     asynchronous, active-low reset
//   i_v     in   1     input word valid
//   i_b     out  1     input back-pressure (1 = not accepting)
//   i_d     in   W     input word (literal or run token)
//   o_v     out  1     output word valid
//   o_b     in   1     output back-pressure from downstream (1 = stall)
//   o_d     out  W     output word
//   stateo  out  2     current FSM state (0 EMPTY, 1 LIT, 2 RUN)

module zld_dec #(
    parameter int W    = 16,
    parameter int CNTW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_v,
    output logic           i_b,
    input  logic [W-1:0]   i_d,
    output logic           o_v,
    input  logic           o_b,
    output logic [W-1:0]   o_d,
    output logic [1:0]     stateo
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LIT     = 2'd1,
        RUN     = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [W-1:0]      data_q, data_nx;
    logic [CNTW-1:0]   rem_q, rem_nx;

    logic              out_fire;
    logic              drain;
    logic              accept;

    // o_v comes straight from the state register, so it drops the moment
    // reset clears the state, without waiting for a clock edge.
    assign o_v      = (state == LIT) || (state == RUN);
    assign out_fire = o_v && !o_b;

    // The word on the output is the last one this decoder owes downstream:
    // either a literal, or the final zero of a run.
    assign drain = out_fire && ((state == LIT) || ((state == RUN) && (rem_q == '0)));

    // o_b reaches i_b combinationally through drain so that a new word can be
    // taken in the same cycle the previous one leaves, giving 1 word/cycle.
    assign i_b    = !reset || !((state == EMPTY) || drain);
    assign accept = i_v && !i_b;

    assign o_d    = data_q;
    assign stateo = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            data_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_nx;
            data_q <= data_nx;
            rem_q  <= rem_nx;
        end
    end

    // Later assignments override earlier ones: a drain empties the slot, and
    // an accept in the same cycle refills it directly, so no bubble appears.
    always_comb begin
        state_nx = state;
        data_nx  = data_q;
        rem_nx   = rem_q;

        if (state == ILLEGAL) begin
            state_nx = EMPTY;
            data_nx  = '0;
            rem_nx   = '0;
        end else begin
            if (drain) begin
                state_nx = EMPTY;
                data_nx  = '0;
            end

            // A run with zeros still outstanding after this one stays in RUN.
            // The rem==0 case goes through drain, so rem never wraps.
            if ((state == RUN) && out_fire && (rem_q != '0)) begin
                rem_nx = rem_q - 1'b1;
            end

            if (accept) begin
                if (i_d[W-1]) begin
                    state_nx = RUN;
                    rem_nx   = i_d[CNTW-1:0];
                    data_nx  = '0;
                end else begin
                    state_nx = LIT;
                    data_nx  = i_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_zld_dec.sv
// tb_zld_dec - directed self-checking bench for zld_dec.
//
// Drives literal words and run tokens into the decoder and records every
// word that leaves it. The recorded stream is checked against an expected
// stream that the bench builds itself. Direct checks cover the reset values,
// the handshake timing, back-pressure holding, and a reset in the middle of
// a run. A randomized stream is encoded by the bench and checked after
// decoding.

module tb_zld_dec;

    logic        clock;
    logic        reset;
    logic        i_v;
    logic        i_b;
    logic [15:0] i_d;
    logic        o_v;
    logic        o_b;
    logic [15:0] o_d;
    logic [1:0]  stateo;

    logic        o_b_dir;
    logic        o_b_rnd;
    logic        use_rnd;

    int          checks;
    int          failures;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    assign o_b = use_rnd ? o_b_rnd : o_b_dir;

    zld_dec #(.W(16), .CNTW(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .i_v    (i_v),
        .i_b    (i_b),
        .i_d    (i_d),
        .o_v    (o_v),
        .o_b    (o_b),
        .o_d    (o_d),
        .stateo (stateo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Random downstream stall, updated just after each rising edge.
    initial begin
        o_b_rnd = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            o_b_rnd = 1'($urandom_range(0, 1));
        end
    end

    // Output transfers are recorded mid-cycle, where o_v/o_b/o_d are stable
    // ahead of the edge that completes the transfer.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && o_v && !o_b) got_q.push_back(o_d);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Presents one word and holds it until it is accepted or the bound expires.
    task automatic applyStimulus(input logic [15:0] d, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        i_v   = 1'b1;
        i_d   = d;
        while (!acc && waits < 300) begin
            @(negedge clock);
            if (!i_b) acc = 1'b1;
            else      waits++;
            @(posedge clock);
            #1;
        end
        i_v = 1'b0;
        checkOutput("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (o_v === 1'b1 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, o_v}, 32'd0);
    endtask

    task automatic compareQueues(input string tag);
        int nmis;
        int lim;
        nmis = 0;
        lim  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < lim; i++) begin
            if (got_q[i] !== exp_q[i]) nmis++;
        end
        checkOutput({tag, "_data"}, nmis, 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pushZeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'h0000);
    endtask

    initial begin
        int          w;
        int          n;
        logic [15:0] orig[$];
        logic [15:0] toks[$];
        logic [15:0] tok;
        int          zrun;
        int          chunk;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        i_v      = 1'b0;
        i_d      = 16'h0000;
        o_b_dir  = 1'b0;
        use_rnd  = 1'b0;

        // Reset values while reset is held low.
        #12;
        checkOutput("rst_ov", {31'd0, o_v}, 32'd0);
        checkOutput("rst_od", {16'd0, o_d}, 32'd0);
        checkOutput("rst_state", {30'd0, stateo}, 32'd0);
        checkOutput("rst_ib", {31'd0, i_b}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rel_ib", {31'd0, i_b}, 32'd0);
        @(posedge clock);
        #1;

        // Back-to-back literals.
        $display("[TB] literal stream");
        applyStimulus(16'h0005, w);
        checkOutput("lit_w0", w, 32'd0);
        checkOutput("lit_ov0", {31'd0, o_v}, 32'd1);
        checkOutput("lit_od0", {16'd0, o_d}, 32'h0005);
        applyStimulus(16'h0007, w);
        checkOutput("lit_w1", w, 32'd0);
        checkOutput("lit_od1", {16'd0, o_d}, 32'h0007);
        applyStimulus(16'h0009, w);
        checkOutput("lit_w2", w, 32'd0);
        checkOutput("lit_od2", {16'd0, o_d}, 32'h0009);
        exp_q.push_back(16'h0005);
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0009);
        waitIdle("lit");
        checkOutput("lit_state", {30'd0, stateo}, 32'd0);
        compareQueues("lit");

        // Short run followed by a literal taken in the last-zero cycle.
        $display("[TB] short run");
        applyStimulus(16'h8003, w);
        checkOutput("run_state", {30'd0, stateo}, 32'd2);
        i_v = 1'b1;
        i_d = 16'h0042;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("run_ib_hi", {31'd0, i_b}, 32'd1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checkOutput("run_ib_lo", {31'd0, i_b}, 32'd0);
        @(posedge clock);
        #1;
        i_v = 1'b0;
        checkOutput("run_od42", {16'd0, o_d}, 32'h0042);
        checkOutput("run_state_lit", {30'd0, stateo}, 32'd1);
        pushZeros(4);
        exp_q.push_back(16'h0042);
        waitIdle("run");
        compareQueues("run");

        // Run length boundaries, including ignored bits in the token.
        $display("[TB] run bounds");
        applyStimulus(16'h800F, w);
        waitIdle("max");
        pushZeros(16);
        compareQueues("max");
        applyStimulus(16'h8000, w);
        waitIdle("min");
        pushZeros(1);
        compareQueues("min");
        applyStimulus(16'hFFF3, w);
        waitIdle("ign");
        pushZeros(4);
        compareQueues("ign");

        // A literal held under back-pressure.
        $display("[TB] back-pressure hold");
        o_b_dir = 1'b1;
        applyStimulus(16'h1234, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("hold_ov", {31'd0, o_v}, 32'd1);
            checkOutput("hold_od", {16'd0, o_d}, 32'h1234);
            checkOutput("hold_ib", {31'd0, i_b}, 32'd1);
            @(posedge clock);
            #1;
        end
        o_b_dir = 1'b0;
        waitIdle("hold");
        exp_q.push_back(16'h1234);
        compareQueues("hold");

        // Back-pressure toggling every cycle during a run.
        $display("[TB] toggled back-pressure");
        applyStimulus(16'h8007, w);
        n = 0;
        while (o_v === 1'b1 && n < 100) begin
            o_b_dir = ~o_b_dir;
            @(posedge clock);
            #1;
            n++;
        end
        o_b_dir = 1'b0;
        checkOutput("tog_idle", {31'd0, o_v}, 32'd0);
        pushZeros(8);
        compareQueues("tog");

        // Reset in the middle of a run.
        $display("[TB] reset mid-run");
        applyStimulus(16'h800F, w);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mrst_ov", {31'd0, o_v}, 32'd0);
        checkOutput("mrst_ib", {31'd0, i_b}, 32'd1);
        checkOutput("mrst_state", {30'd0, stateo}, 32'd0);
        checkOutput("mrst_od", {16'd0, o_d}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mrel_ib", {31'd0, i_b}, 32'd0);
        checkOutput("mrel_state", {30'd0, stateo}, 32'd0);
        @(posedge clock);
        #1;
        pushZeros(2);
        applyStimulus(16'h0011, w);
        checkOutput("mrel_od", {16'd0, o_d}, 32'h0011);
        waitIdle("mrel");
        exp_q.push_back(16'h0011);
        compareQueues("mrst");

        // Random stream, zero-run encoded here, decoded under random stalls.
        $display("[TB] random round trip");
        while (orig.size() < 400) begin
            if ($urandom_range(0, 99) < 30) begin
                n = $urandom_range(1, 40);
                for (int i = 0; i < n; i++) orig.push_back(16'h0000);
            end else begin
                orig.push_back(16'($urandom_range(1, 16'h7FFF)));
            end
        end
        zrun = 0;
        for (int i = 0; i <= orig.size(); i++) begin
            if (i < orig.size() && orig[i] == 16'h0000) begin
                zrun++;
            end else begin
                while (zrun > 0) begin
                    chunk       = (zrun > 16) ? 16 : zrun;
                    tok         = 16'h8000;
                    tok[14:4]   = 11'($urandom);
                    tok[3:0]    = 4'(chunk - 1);
                    toks.push_back(tok);
                    zrun       -= chunk;
                end
                if (i < orig.size()) toks.push_back(orig[i]);
            end
        end
        use_rnd = 1'b1;
        foreach (toks[i]) applyStimulus(toks[i], w);
        waitIdle("rt");
        use_rnd = 1'b0;
        foreach (orig[i]) exp_q.push_back(orig[i]);
        compareQueues("rt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
